// File: rtl/fsm_ctx_scheduler_pkg.sv
// Shared types and helpers for the context-switched Moore scheduler:
// state encoding, transition/output functions and requester-count limits.
package fsm_ctx_pkg;

  localparam int NREQ_MIN = 2;
  localparam int NREQ_MAX = 8;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  function automatic state_t calc_next(state_t s, logic x);
    state_t n;
    n = S0;
    case (s)
      S0: n = x ? S2 : S1;
      S1: n = x ? S3 : S0;
      S2: n = x ? S2 : S3;
      S3: n = x ? S0 : S2;
      default: n = S0;
    endcase
    return n;
  endfunction

  function automatic logic calc_out(state_t s);
    return (s == S0) || (s == S1);
  endfunction

endpackage

// File: rtl/fsm_ctx_scheduler_if.sv
// Requester/response bundle between the bit sources, the scheduler and the
// downstream collector. The scheduler uses the slave view.
interface fsm_ctx_scheduler_if
  import fsm_ctx_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) ();

  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_bit;
  logic [NREQ-1:0] req_ready;
  logic [NREQ-1:0] ctx_clr;
  logic            resp_valid;
  logic [IDW-1:0]  resp_id;
  logic            resp_out;
  state_t          resp_state;
  logic            resp_ready;

  modport master (
    output req_valid, req_bit, ctx_clr, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_out, resp_state
  );

  modport slave (
    input  req_valid, req_bit, ctx_clr, resp_ready,
    output req_ready, resp_valid, resp_id, resp_out, resp_state
  );

endinterface

// File: rtl/fsm_ctx_scheduler_moore4_core.sv
// Shared 4-state Moore core: pure combinational (state, x) -> (next, out).
module moore4_core
  import fsm_ctx_pkg::*;
(
  input  state_t state,
  input  logic   x,
  output state_t next_state,
  output logic   out
);

  assign next_state = calc_next(state, x);
  assign out        = calc_out(state);

endmodule

// File: rtl/fsm_ctx_scheduler.sv
// Round-robin scheduler that time-shares one Moore core among NREQ requesters,
// each with its own saved state, and registers one response per grant.
module fsm_ctx_scheduler
  import fsm_ctx_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               reset,
  fsm_ctx_scheduler_if.slave bus
);

  if (NREQ < NREQ_MIN || NREQ > NREQ_MAX) begin : g_bad_nreq
    $error("fsm_ctx_scheduler: NREQ out of supported range");
  end

  state_t          ctx_q [NREQ];
  state_t          ctx_d [NREQ];
  logic [IDW-1:0]  rr_q, rr_d;
  logic            resp_valid_q, resp_valid_d;
  logic [IDW-1:0]  resp_id_q, resp_id_d;
  logic            resp_out_q, resp_out_d;
  state_t          resp_state_q, resp_state_d;

  logic            stall;
  logic            grant;
  logic [IDW-1:0]  grant_id;
  logic [IDW-1:0]  cand;
  state_t          cur_state;
  state_t          core_next;
  logic            core_out;

  assign stall = resp_valid_q && !bus.resp_ready;

  // Search starts at rr_q and wraps; the first valid requester wins.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant    = 1'b0;
    grant_id = '0;
    cand     = '0;
    if (!reset && !stall) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = IDW'((int'(rr_q) + k) % NREQ);
        if (!grant && bus.req_valid[cand]) begin
          grant    = 1'b1;
          grant_id = cand;
        end
      end
    end
  end

  assign bus.req_ready = grant ? (NREQ'(1) << grant_id) : '0;

  assign cur_state = ctx_q[grant_id];

  moore4_core u_core (
    .state      (cur_state),
    .x          (bus.req_bit[grant_id]),
    .next_state (core_next),
    .out        (core_out)
  );

  always_comb begin
    ctx_d        = ctx_q;
    rr_d         = rr_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_out_d   = resp_out_q;
    resp_state_d = resp_state_q;

    if (grant) begin
      rr_d         = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
      resp_valid_d = 1'b1;
      resp_id_d    = grant_id;
      resp_out_d   = core_out;
      resp_state_d = core_next;
    end else if (resp_valid_q && bus.resp_ready) begin
      resp_valid_d = 1'b0;
    end

    // Clear overrides the granted update; the response still reflects it.
    for (int i = 0; i < NREQ; i++) begin
      if (bus.ctx_clr[i]) begin
        ctx_d[i] = S0;
      end else if (grant && grant_id == IDW'(i)) begin
        ctx_d[i] = core_next;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the context table is a handful of flops, so it is reset like any register.
      for (int i = 0; i < NREQ; i++) ctx_q[i] <= S0;
      rr_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_out_q   <= 1'b0;
      resp_state_q <= S0;
    end else begin
      ctx_q        <= ctx_d;
      rr_q         <= rr_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_out_q   <= resp_out_d;
      resp_state_q <= resp_state_d;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_out   = resp_out_q;
  assign bus.resp_state = resp_state_q;

endmodule

// File: tb/tb_fsm_ctx_scheduler.sv
// Self-checking bench for fsm_ctx_scheduler: directed scenarios plus random
// traffic, compared against a table-driven per-requester reference model.
module tb_fsm_ctx_scheduler;
  import fsm_ctx_pkg::*;

  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fsm_ctx_scheduler_if #(.NREQ(NREQ)) bus ();

  fsm_ctx_scheduler #(.NREQ(NREQ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: states as integers 0..3, transitions by lookup table.
  int nxt_tab [4][2] = '{'{1, 2}, '{0, 3}, '{3, 2}, '{2, 0}};
  int out_tab [4]    = '{1, 1, 0, 0};
  int m_ctx [NREQ];
  int m_rr;
  bit m_rv;
  int m_id, m_out, m_st;

  function automatic int model_pick(logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++)
      if (v[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
    return -1;
  endfunction

  task automatic step(logic rst, logic [NREQ-1:0] v, logic [NREQ-1:0] b,
                      logic [NREQ-1:0] clr, logic rr);
    int g, s, n;
    logic [NREQ-1:0] exp_rdy;
    reset          = rst;
    bus.req_valid  = v;
    bus.req_bit    = b;
    bus.ctx_clr    = clr;
    bus.resp_ready = rr;
    #1;
    g = (rst || (m_rv && !rr)) ? -1 : model_pick(v);
    exp_rdy = (g < 0) ? '0 : (NREQ'(1) << g);
    check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NREQ; i++) m_ctx[i] = 0;
      m_rr = 0; m_rv = 0; m_id = 0; m_out = 0; m_st = 0;
    end else begin
      if (g >= 0) begin
        s        = m_ctx[g];
        n        = nxt_tab[s][b[g]];
        m_id     = g;
        m_out    = out_tab[s];
        m_st     = n;
        m_rv     = 1;
        m_rr     = (g + 1) % NREQ;
        m_ctx[g] = n;
      end else if (m_rv && rr) begin
        m_rv = 0;
      end
      for (int i = 0; i < NREQ; i++) if (clr[i]) m_ctx[i] = 0;
    end
    #1;
    check("resp_valid", 32'(bus.resp_valid), 32'(m_rv));
    check("resp_id",    32'(bus.resp_id),    32'(m_id));
    check("resp_out",   32'(bus.resp_out),   32'(m_out));
    check("resp_state", 32'(bus.resp_state), 32'(m_st));
  endtask

  int t1_out [4] = '{1, 1, 1, 0};
  int t1_st  [4] = '{1, 0, 2, 2};

  initial begin
    reset          = 1'b1;
    bus.req_valid  = '0;
    bus.req_bit    = '0;
    bus.ctx_clr    = '0;
    bus.resp_ready = 1'b1;

    // Reset state
    step(1'b1, '0, '0, '0, 1'b1);
    step(1'b1, 4'hF, 4'hF, '0, 1'b1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_state", 32'(bus.resp_state), 32'd0);

    // Requester 0 sends 0,0,1,1
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 4'b0001, {3'b000, (k >= 2) ? 1'b1 : 1'b0}, '0, 1'b1);
      check("t1_out", 32'(bus.resp_out),   32'(t1_out[k]));
      check("t1_st",  32'(bus.resp_state), 32'(t1_st[k]));
      check("t1_id",  32'(bus.resp_id),    32'd0);
    end

    // All four continuously valid: round-robin 0,1,2,3,...
    step(1'b1, '0, '0, '0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 4'hF, NREQ'($urandom), '0, 1'b1);
      check("t3_id", 32'(bus.resp_id), 32'(k % 4));
    end

    // Three stalled cycles, then resume at the pre-stall pointer owner
    for (int k = 0; k < 3; k++) step(1'b0, 4'hF, NREQ'($urandom), '0, 1'b0);
    step(1'b0, 4'hF, NREQ'($urandom), '0, 1'b1);
    check("t4_resume_id", 32'(bus.resp_id), 32'd0);

    // Clear on the same cycle as a grant to requester 2 in S3
    step(1'b1, '0, '0, '0, 1'b1);
    step(1'b0, 4'b0100, 4'b0000, '0, 1'b1);
    step(1'b0, 4'b0100, 4'b0100, '0, 1'b1);
    check("t5_pre_st", 32'(bus.resp_state), 32'd3);
    step(1'b0, 4'b0100, 4'b0100, 4'b0100, 1'b1);
    check("t5_clr_out", 32'(bus.resp_out),   32'd0);
    check("t5_clr_st",  32'(bus.resp_state), 32'd0);
    step(1'b0, 4'b0100, 4'b0000, '0, 1'b1);
    check("t5_after_out", 32'(bus.resp_out),   32'd1);
    check("t5_after_st",  32'(bus.resp_state), 32'd1);

    // Reset mid-stream with a live response
    step(1'b0, 4'hF, 4'hF, '0, 1'b1);
    step(1'b0, 4'hF, 4'hF, '0, 1'b0);
    step(1'b1, 4'hF, 4'hF, '0, 1'b0);
    check("t6_rv", 32'(bus.resp_valid), 32'd0);
    step(1'b0, 4'hF, 4'h0, '0, 1'b1);
    check("t6_id", 32'(bus.resp_id),    32'd0);
    check("t6_st", 32'(bus.resp_state), 32'd1);

    // Requester 1 alone sends x=1 ten times; others stay in S0
    step(1'b1, '0, '0, '0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 4'b0010, 4'b0010, '0, 1'b1);
      check("t7_st",  32'(bus.resp_state), 32'd2);
      check("t7_out", 32'(bus.resp_out),   (k == 0) ? 32'd1 : 32'd0);
    end
    for (int r = 0; r < NREQ; r++) begin
      if (r != 1) begin
        step(1'b0, NREQ'(1) << r, '0, '0, 1'b1);
        check("t7_other_st",  32'(bus.resp_state), 32'd1);
        check("t7_other_out", 32'(bus.resp_out),   32'd1);
      end
    end

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      logic [NREQ-1:0] clr;
      for (int i = 0; i < NREQ; i++) clr[i] = ($urandom_range(0, 15) == 0);
      step(($urandom_range(0, 63) == 0), NREQ'($urandom), NREQ'($urandom), clr,
           ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
